// File: rtl/bht_counter_table.sv
// ---------------------------------------------------------------------------
// bht_counter_table
//
// Branch history table of saturating counters for the fetch stage. Lookups
// are indexed by low PC bits and return a registered prediction one cycle
// later. Execute trains entries with resolved branch/jump outcomes. A
// sequenced clear sweep rewrites every entry with INIT_STATE without needing
// the asynchronous reset.
//
// Optional feature (file-level macro):
//   BHT_UPDATE_BYPASS_EN - when defined, a lookup and an update to the same
//                          index in the same cycle return the post-update
//                          counter value. When undefined, such a lookup
//                          returns the value held before the edge.
//
// Parameters:
//   INDEX_W     index width, table depth is 2**INDEX_W
//   CTR_W       counter width per entry (1..4)
//   INIT_STATE  value loaded on reset and on clear (< 2**CTR_W)
//
// Ports:
//   clk           rising-edge clock
//   arst_n        asynchronous active-low reset
//   en            global enable, 0 freezes all state and drops pred_valid
//   lookup_valid  lookup request this cycle
//   lookup_idx    entry to read
//   upd_valid     training update this cycle
//   upd_idx       entry to train
//   upd_taken     resolved outcome (1 = taken)
//   clear_req     single-cycle pulse starting a clear sweep
//   pred_valid    prediction outputs valid
//   pred_taken    predicted direction (counter MSB)
//   pred_ctr      full counter value read
//   busy          clear sweep in progress
// ---------------------------------------------------------------------------
module bht_counter_table #(
    parameter int INDEX_W    = 5,
    parameter int CTR_W      = 2,
    parameter int INIT_STATE = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               en,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_idx,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_taken,
    input  logic               clear_req,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [CTR_W-1:0]   pred_ctr,
    output logic               busy
);

    localparam int                 DEPTH    = 1 << INDEX_W;
    localparam logic [CTR_W-1:0]   INIT_VAL = CTR_W'(INIT_STATE);
    localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]   CTR_MIN  = '0;
    localparam logic [INDEX_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic [CTR_W-1:0]   ctr_q [DEPTH];
    logic [CTR_W-1:0]   ctr_d [DEPTH];
    logic               pred_valid_q, pred_valid_d;
    logic [CTR_W-1:0]   pred_ctr_q, pred_ctr_d;

    logic               upd_fire;
    logic [CTR_W-1:0]   upd_cur;
    logic [CTR_W-1:0]   upd_value;

    // An update is dropped while sweeping and when a clear starts in the same
    // cycle, so the clear always wins over training.
    assign upd_fire = en && upd_valid && (state_q == IDLE) && !clear_req;
    assign upd_cur  = ctr_q[upd_idx];

    // Saturating step: never wraps past either end of the counter range.
    always_comb begin
        upd_value = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) begin
                upd_value = upd_cur + 1'b1;
            end
        end else begin
            if (upd_cur != CTR_MIN) begin
                upd_value = upd_cur - 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ctr_d        = ctr_q;
        pred_valid_d = 1'b0;
        pred_ctr_d   = pred_ctr_q;

        if (en) begin
            pred_valid_d = lookup_valid;

            // During a sweep the table contents are in transition, so every
            // lookup reports the clear value regardless of what is stored.
            if (lookup_valid) begin
                if (state_q == CLEAR) begin
                    pred_ctr_d = INIT_VAL;
                end else begin
`ifdef BHT_UPDATE_BYPASS_EN
                    if (upd_fire && (upd_idx == lookup_idx)) begin
                        pred_ctr_d = upd_value;
                    end else begin
                        pred_ctr_d = ctr_q[lookup_idx];
                    end
`else
                    pred_ctr_d = ctr_q[lookup_idx];
`endif
                end
            end

            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_d = CLEAR;
                        ptr_d   = '0;
                    end
                end
                CLEAR: begin
                    ctr_d[ptr_q] = INIT_VAL;
                    ptr_d        = ptr_q + 1'b1;
                    if (ptr_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (upd_fire) begin
                ctr_d[upd_idx] = upd_value;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            ctr_q        <= '{default: INIT_VAL};
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_taken = pred_ctr_q[CTR_W-1];
    assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_bht_counter_table.sv
// ---------------------------------------------------------------------------
// tb_bht_counter_table
//
// Self-checking bench for bht_counter_table. Directed scenarios and a random
// phase are compared every cycle against a table-level reference model.
// Honours BHT_UPDATE_BYPASS_EN when the same macro is given to the build.
// ---------------------------------------------------------------------------
module tb_bht_counter_table;

    localparam int INDEX_W    = 5;
    localparam int CTR_W      = 2;
    localparam int INIT_STATE = 1;
    localparam int DEPTH      = 1 << INDEX_W;
    localparam int MAXV       = (1 << CTR_W) - 1;
    localparam int MSB_WEIGHT = 1 << (CTR_W - 1);

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic               en = 1'b0;
    logic               lookup_valid = 1'b0;
    logic [INDEX_W-1:0] lookup_idx = '0;
    logic               upd_valid = 1'b0;
    logic [INDEX_W-1:0] upd_idx = '0;
    logic               upd_taken = 1'b0;
    logic               clear_req = 1'b0;
    logic               pred_valid;
    logic               pred_taken;
    logic [CTR_W-1:0]   pred_ctr;
    logic               busy;

    bht_counter_table #(
        .INDEX_W   (INDEX_W),
        .CTR_W     (CTR_W),
        .INIT_STATE(INIT_STATE)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .en          (en),
        .lookup_valid(lookup_valid),
        .lookup_idx  (lookup_idx),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .clear_req   (clear_req),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_ctr    (pred_ctr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer table plus sweep progress.
    int mem [DEPTH];
    bit sweeping;
    int sweep_pos;
    bit exp_valid;
    int exp_ctr;
    bit chk_ctr;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int trained(input int v, input bit t);
        if (t) return (v + 1 > MAXV) ? MAXV : v + 1;
        else   return (v - 1 < 0) ? 0 : v - 1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mem[i] = INIT_STATE;
        sweeping  = 1'b0;
        sweep_pos = 0;
        exp_valid = 1'b0;
        exp_ctr   = 0;
        chk_ctr   = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // wait past the edge so outputs are sampled away from it.
    task automatic applyStimulus(input bit e, input bit lv, input int li,
                                 input bit uv, input int ui, input bit ut,
                                 input bit cr);
        bit upd_eff;
        en           = e;
        lookup_valid = lv;
        lookup_idx   = INDEX_W'(li);
        upd_valid    = uv;
        upd_idx      = INDEX_W'(ui);
        upd_taken    = ut;
        clear_req    = cr;

        upd_eff = e && uv && !sweeping && !cr;
        if (e) begin
            exp_valid = lv;
            if (lv) begin
                if (sweeping) begin
                    exp_ctr = INIT_STATE;
                end else begin
                    exp_ctr = mem[li];
`ifdef BHT_UPDATE_BYPASS_EN
                    if (upd_eff && ui == li) exp_ctr = trained(mem[ui], ut);
`endif
                end
            end
            if (sweeping) begin
                mem[sweep_pos] = INIT_STATE;
                sweep_pos++;
                if (sweep_pos == DEPTH) sweeping = 1'b0;
            end else if (cr) begin
                sweeping  = 1'b1;
                sweep_pos = 0;
            end
            if (upd_eff) mem[ui] = trained(mem[ui], ut);
        end else begin
            exp_valid = 1'b0;
        end
        chk_ctr = exp_valid || !e;

        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [CTR_W-1:0] ev;
        logic             et;
        ev = CTR_W'(exp_ctr);
        et = (exp_ctr >= MSB_WEIGHT);
        n_assert++;
        assert (pred_valid === exp_valid) else begin
            n_fail++;
            $error("[TB] FAIL %s pred_valid: got %0b expected %0b", tag, pred_valid, exp_valid);
        end
        n_assert++;
        assert (busy === sweeping) else begin
            n_fail++;
            $error("[TB] FAIL %s busy: got %0b expected %0b", tag, busy, sweeping);
        end
        if (chk_ctr) begin
            n_assert++;
            assert (pred_ctr === ev) else begin
                n_fail++;
                $error("[TB] FAIL %s pred_ctr: got %0d expected %0d", tag, pred_ctr, ev);
            end
            n_assert++;
            assert (pred_taken === et) else begin
                n_fail++;
                $error("[TB] FAIL %s pred_taken: got %0b expected %0b", tag, pred_taken, et);
            end
        end
    endtask

    task automatic step(input bit e, input bit lv, input int li, input bit uv,
                        input int ui, input bit ut, input bit cr, input string tag);
        applyStimulus(e, lv, li, uv, ui, ut, cr);
        checkOutput(tag);
    endtask

    task automatic checkResetState(input string tag);
        n_assert++;
        assert (busy === 1'b0 && pred_valid === 1'b0 && pred_ctr === '0 && pred_taken === 1'b0) else begin
            n_fail++;
            $error("[TB] FAIL %s: got busy=%0b pv=%0b ctr=%0d pt=%0b expected 0/0/0/0",
                   tag, busy, pred_valid, pred_ctr, pred_taken);
        end
    endtask

    initial begin
        int busy_cycles;
        int r;

        $display("[TB] start");
        modelReset();
        #12;
        checkResetState("reset_values");
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset value read through a lookup.
        step(1, 1, 7, 0, 0, 0, 0, "lookup7_init");

        // Saturate upward, then downward without wrapping.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 3, 1, 0, "train3_up");
        step(1, 1, 3, 0, 0, 0, 0, "lookup3_sat_hi");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 3, 0, 0, "train3_down");
        step(1, 1, 3, 0, 0, 0, 0, "lookup3_sat_lo");
        step(1, 0, 0, 1, 3, 0, 0, "train3_down_extra");
        step(1, 1, 3, 0, 0, 0, 0, "lookup3_no_wrap");

        // Same-cycle lookup and update on idx 9.
        step(1, 1, 9, 1, 9, 1, 0, "same_cycle_idx9");
        step(1, 1, 9, 0, 0, 0, 0, "after_same_cycle_idx9");

        // Train ends of the table, then clear with an ignored second request.
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 1, 0, 1, 0, "train0");
            step(1, 0, 0, 1, 31, 1, 0, "train31");
        end
        step(1, 1, 31, 0, 0, 0, 1, "clear_start");
        busy_cycles = 0;
        for (int c = 0; c < 40 && busy === 1'b1; c++) begin
            busy_cycles++;
            step(1, (c == 3), 0, 0, 0, 0, (c == 9), "sweep1");
        end
        n_assert++;
        assert (busy_cycles === DEPTH) else begin
            n_fail++;
            $error("[TB] FAIL busy_length: got %0d expected %0d", busy_cycles, DEPTH);
        end
        step(1, 1, 0, 0, 0, 0, 0, "post_clear_idx0");
        step(1, 1, 31, 0, 0, 0, 0, "post_clear_idx31");

        // Clear beats a same-cycle update; lookups during the sweep read INIT.
        step(1, 0, 0, 1, 4, 1, 1, "clear_vs_update");
        step(1, 1, 4, 1, 4, 1, 0, "sweep_lookup4");
        for (int c = 0; c < 40 && busy === 1'b1; c++) step(1, 0, 0, 0, 0, 0, 0, "sweep2");
        step(1, 1, 4, 0, 0, 0, 0, "post_clear_idx4");

        // Disable: no prediction, no training, outputs hold.
        step(1, 1, 9, 0, 0, 0, 0, "pre_disable_lookup");
        for (int i = 0; i < 4; i++) step(0, 1, 9, 1, 9, 1, (i == 2), "disabled");
        step(1, 1, 9, 0, 0, 0, 0, "post_disable_idx9");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, 1),
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, 1),
                 (r < 2), "random");
        end
        for (int c = 0; c < 80 && busy === 1'b1; c++) step(1, 0, 0, 0, 0, 0, 0, "drain");

        // Reset in the middle of a sweep.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 20, 1, 0, "train20");
        step(1, 0, 0, 0, 0, 0, 1, "clear_for_reset");
        for (int c = 0; c < 12; c++) step(1, 0, 0, 0, 0, 0, 0, "sweep3");
        arst_n = 1'b0;
        #1;
        modelReset();
        checkResetState("reset_mid_sweep");
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("after_reset_release");
        for (int i = 0; i < DEPTH; i++) step(1, 1, i, 0, 0, 0, 0, "post_reset_scan");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_counter_table.md
# bht_counter_table

Parametrised branch history table of saturating counters, indexed by low PC bits, in the fetch stage of the pipelined core. It predicts taken or not-taken one cycle after a lookup and trains counters from resolved branches and jumps sent by execute. A sequenced table clear supports context switches and test resets without asserting `arst_n`.

## Interface
- `INDEX_W`, 5, index width; table depth is 2^INDEX_W entries.
- `CTR_W`, 2, counter width per entry; legal range 1..4.
- `INIT_STATE`, 1, counter value loaded on reset and on clear; must be < 2^CTR_W.
- `clk`  in  1  clock, rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global enable; 0 freezes all state.
- `lookup_valid`  in  1  lookup request this cycle.
- `lookup_idx`  in  INDEX_W  entry to read.
- `upd_valid`  in  1  training update this cycle.
- `upd_idx`  in  INDEX_W  entry to train.
- `upd_taken`  in  1  resolved outcome (branch taken or jump executed).
- `clear_req`  in  1  single-cycle pulse that starts a table clear sweep.
- `pred_valid`  out  1  prediction outputs valid.
- `pred_taken`  out  1  predicted direction, the counter MSB.
- `pred_ctr`  out  CTR_W  full counter value read.
- `busy`  out  1  clear sweep in progress.

## Operation
- Storage: 2^INDEX_W registers of CTR_W bits. `arst_n` low loads every entry with INIT_STATE.
- Update with `upd_taken`=1: the counter increments and saturates at 2^CTR_W−1. Update with `upd_taken`=0: the counter decrements and saturates at 0. No wrap-around in either direction.
- Lookup: registered read of entry `lookup_idx`. `pred_taken` = `pred_ctr[CTR_W-1]`.
- Clear FSM states:
  - IDLE -> CLEAR on `clear_req`=1 and `en`=1. The sweep pointer loads 0.
  - In CLEAR, each enabled cycle writes INIT_STATE to the entry at the pointer, then increments the pointer.
  - CLEAR -> IDLE in the cycle that writes entry 2^INDEX_W−1.
  - `busy` = (state == CLEAR).
- During CLEAR:
  - Updates are dropped.
  - Lookups still return `pred_valid`=1 with `pred_ctr`=INIT_STATE, whatever the entry holds.
- `clear_req` while `busy` is ignored; the sweep does not restart.
- `clear_req` and `upd_valid` in the same cycle: the clear wins and the update is dropped.
- `en`=0 has these effects:
  - No counter writes.
  - The sweep pointer and FSM hold.
  - `pred_valid` is driven to 0 on the next edge.
  - `pred_taken` and `pred_ctr` hold.
- Reset mid-sweep: the FSM returns to IDLE, `busy` goes to 0, and all entries load INIT_STATE.

## Timing
- Reset values: `pred_valid`=0, `pred_taken`=0, `pred_ctr`=0, `busy`=0, FSM=IDLE.
- Lookup latency is 1 cycle. A lookup accepted at edge N gives a prediction valid after edge N+1. `pred_valid` stays high only for cycles following an accepted lookup.
- An update accepted at edge N is visible to a lookup issued at edge N+1 or later.
- A clear pulse at edge N raises `busy` after edge N+1. The sweep takes 2^INDEX_W enabled cycles; `busy` drops after the edge that writes the last entry.
- Same-index lookup and update in the same cycle: the lookup returns the pre-update value, unless the macro below is defined.

## Configuration
- `BHT_UPDATE_BYPASS_EN` defined: a same-cycle, same-index lookup and update returns the post-update (saturated) counter value. Lookups during CLEAR are unaffected.
- `BHT_UPDATE_BYPASS_EN` undefined: no forwarding; the lookup returns the value held before the edge.

## Test plan
Defaults for all scenarios: INDEX_W=5, CTR_W=2, INIT_STATE=1.
- Reset, then lookup idx 7 -> next cycle `pred_valid`=1, `pred_ctr`=1, `pred_taken`=0.
- Four taken updates to idx 3, then lookup -> `pred_ctr`=3 (saturated), `pred_taken`=1. Three not-taken updates, then lookup -> `pred_ctr`=0, with no wrap to 3.
- Same-cycle lookup and taken update to idx 9 (counter at 1) -> `pred_ctr`=1 without the macro, 2 with `BHT_UPDATE_BYPASS_EN`.
- Train idx 0 and idx 31 to 3, pulse `clear_req` -> `busy` high for exactly 32 cycles. A second `clear_req` at cycle 10 has no effect. Afterwards, lookups of idx 0 and idx 31 -> `pred_ctr`=1.
- `clear_req` and a taken update to idx 4 in the same cycle -> after the sweep, idx 4 reads 1. A lookup of idx 4 during the sweep reads 1.
- `en`=0 while issuing lookups and updates -> `pred_valid`=0 and counters are unchanged. Assert `arst_n`=0 at sweep cycle 12 -> `busy`=0 immediately and all entries read INIT_STATE.
